pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It selects the next PC from NUM_SRC externally computed candidates. It also handles pipeline stall, exception entry, eret return, and an instruction-memory ready handshake that can buffer a redirect. It flags illegal fetch addresses so the pipeline can raise a fetch exception.

---
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: next-PC candidates and control in, fetch address and status out.
// The master side is the pipeline; the slave side is pc_gen.
interface pc_gen_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SEL_W   = 3
);
  logic [SEL_W-1:0]         next_pc_sel;
  logic [NUM_SRC*WIDTH-1:0] next_pc_in;
  logic                     stall;
  logic                     req_exc;
  logic                     eret;
  logic [WIDTH-1:0]         epc;
  logic                     imem_ready;
  logic [WIDTH-1:0]         pc_out;
  logic [WIDTH-1:0]         pc_plus4;
  logic                     fetch_exc;
  logic                     fetch_valid;
  logic                     busy;

  modport master (
    output next_pc_sel, next_pc_in, stall, req_exc, eret, epc, imem_ready,
    input  pc_out, pc_plus4, fetch_exc, fetch_valid, busy
  );

  modport slave (
    input  next_pc_sel, next_pc_in, stall, req_exc, eret, epc, imem_ready,
    output pc_out, pc_plus4, fetch_exc, fetch_valid, busy
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: picks the next fetch PC from NUM_SRC candidates, handles
// stall, exception entry, eret, and buffers one redirect while instruction memory is not ready.
//
// state | meaning
// RUN   | normal fetch; PC follows the selected candidate when memory is ready
// HOLD  | a redirect is buffered in pend, waiting for imem_ready with no stall
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_SRC   = 8,
  parameter int unsigned      SEL_W     = 3,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] TEXT_HI   = 32'h0000_6ffc
) (
  input logic        clk,
  input logic        reset,
  pc_gen_if.slave    bus
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] cand;

  assign pc_plus4 = pc_q + WIDTH'(4);

  // Out-of-range selects fall back to sequential fetch.
  always_comb begin
    cand = pc_plus4;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (int'(bus.next_pc_sel) == i) begin
        cand = bus.next_pc_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    state_d = state_q;
    if (bus.req_exc) begin
      pc_d    = EXC_VEC;
      state_d = RUN;
    end else if (bus.eret) begin
      pc_d    = bus.epc;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.stall) begin
            if (bus.imem_ready) begin
              pc_d = cand;
            end else begin
              pend_d  = cand;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.imem_ready && !bus.stall) begin
            pc_d    = pend_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_exc   = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  assign bus.fetch_valid = bus.imem_ready && !bus.fetch_exc && (state_q == RUN);
  assign bus.busy        = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table plus randomized run against a queue-based model.
module tb_pc_gen;
  localparam int NS = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.WIDTH(32), .NUM_SRC(NS), .SEL_W(3)) bus ();

  pc_gen #(.WIDTH(32), .NUM_SRC(NS), .SEL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rst, stall, exc, eret, rdy;
    logic [2:0]  sel;
    logic [31:0] slot, epc, exp_pc;
    bit          exp_busy, exp_fexc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] slot [NS];
  bit          c_rst, c_stall, c_exc, c_eret, c_rdy;
  logic [2:0]  c_sel;
  logic [31:0] c_epc;

  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit rst, stall, exc, eret, rdy, input logic [2:0] sel,
                     input logic [31:0] sv, epc, ep, input bit eb, ef);
    vec_t v;
    v.rst = rst; v.stall = stall; v.exc = exc; v.eret = eret; v.rdy = rdy;
    v.sel = sel; v.slot = sv; v.epc = epc; v.exp_pc = ep; v.exp_busy = eb; v.exp_fexc = ef;
    tbl.push_back(v);
  endtask

  task automatic drive();
    reset           = c_rst;
    bus.stall       = c_stall;
    bus.req_exc     = c_exc;
    bus.eret        = c_eret;
    bus.imem_ready  = c_rdy;
    bus.next_pc_sel = c_sel;
    bus.epc         = c_epc;
    for (int i = 0; i < NS; i++) bus.next_pc_in[i*32 +: 32] = slot[i];
  endtask

  // Reference: PC follows the rules in priority order; pending redirects live in a queue.
  task automatic tick();
    logic [31:0] cand;
    drive();
    cand = (int'(c_sel) < NS) ? slot[c_sel] : m_pc + 32'd4;
    if (c_rst) begin
      m_pc = 32'h3000; m_pend.delete();
    end else if (c_exc) begin
      m_pc = 32'h4180; m_pend.delete();
    end else if (c_eret) begin
      m_pc = c_epc; m_pend.delete();
    end else if (m_pend.size() != 0) begin
      if (c_rdy && !c_stall) m_pc = m_pend.pop_front();
    end else if (!c_stall) begin
      if (c_rdy) m_pc = cand;
      else m_pend.push_back(cand);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6ffc);
  endfunction

  task automatic check_model(input string tag);
    bit mb, mf;
    mb = (m_pend.size() != 0);
    mf = bad_addr(m_pc);
    chk({tag, ".pc_out"}, bus.pc_out, m_pc);
    chk({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, ".fetch_exc"}, 32'(bus.fetch_exc), 32'(mf));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(mb));
    chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(c_rdy && !mf && !mb));
  endtask

  initial begin
    // rst stall exc eret rdy sel slot epc | exp_pc busy fexc
    add(0,0,0,0,1, 3'd0, 32'h3004, 0,        32'h3004, 0, 0);
    add(0,0,0,0,1, 3'd0, 32'h3008, 0,        32'h3008, 0, 0);
    add(0,1,0,0,1, 3'd0, 32'h3999, 0,        32'h3008, 0, 0);
    add(0,1,0,0,1, 3'd0, 32'h3999, 0,        32'h3008, 0, 0);
    add(0,1,0,0,1, 3'd0, 32'h3999, 0,        32'h3008, 0, 0);
    add(0,1,1,0,0, 3'd0, 32'h3999, 0,        32'h4180, 0, 0);
    add(0,0,1,1,1, 3'd0, 32'h3999, 32'h3010, 32'h4180, 0, 0);
    add(0,0,0,1,1, 3'd0, 32'h3999, 32'h3010, 32'h3010, 0, 0);
    add(0,0,0,0,1, 3'd2, 32'h3400, 0,        32'h3400, 0, 0);
    add(0,0,0,0,1, 3'd7, 32'h5000, 0,        32'h3404, 0, 0);
    add(0,0,0,0,0, 3'd1, 32'h3100, 0,        32'h3404, 1, 0);
    add(0,0,0,0,0, 3'd1, 32'h3200, 0,        32'h3404, 1, 0);
    add(0,0,0,0,1, 3'd1, 32'h3300, 0,        32'h3100, 0, 0);
    add(0,0,0,0,0, 3'd1, 32'h3500, 0,        32'h3100, 1, 0);
    add(0,0,1,0,0, 3'd1, 32'h3500, 0,        32'h4180, 0, 0);
    add(0,0,0,0,1, 3'd7, 32'h3500, 0,        32'h4184, 0, 0);
    add(0,0,0,0,0, 3'd1, 32'h3600, 0,        32'h4184, 1, 0);
    add(1,0,0,0,0, 3'd1, 32'h3600, 0,        32'h3000, 0, 0);
    add(0,0,0,0,1, 3'd7, 32'h3600, 0,        32'h3004, 0, 0);
    add(0,0,0,0,1, 3'd3, 32'h3002, 0,        32'h3002, 0, 1);
    add(0,0,0,0,1, 3'd3, 32'h7000, 0,        32'h7000, 0, 1);
    add(0,0,0,0,1, 3'd3, 32'h6ffc, 0,        32'h6ffc, 0, 0);
    add(0,0,0,0,1, 3'd3, 32'h2ffc, 0,        32'h2ffc, 0, 1);
    add(0,0,0,0,1, 3'd7, 32'h2ffc, 0,        32'h3000, 0, 0);
    add(0,0,0,0,1, 3'd3, 32'hffff_fffc, 0,   32'hffff_fffc, 0, 1);
    add(0,0,0,0,1, 3'd7, 32'h3000, 0,        32'h0000_0000, 0, 1);
    add(0,0,0,0,0, 3'd1, 32'h3700, 0,        32'h0000_0000, 1, 1);
    add(0,1,0,0,1, 3'd1, 32'h3800, 0,        32'h0000_0000, 1, 1);
    add(0,0,0,0,1, 3'd1, 32'h3900, 0,        32'h3700, 0, 0);

    for (int i = 0; i < NS; i++) slot[i] = 32'h0000_5550;
    c_rst = 1; c_stall = 0; c_exc = 0; c_eret = 0; c_rdy = 1; c_sel = 3'd0; c_epc = 32'h0;
    m_pc = 32'h0;
    drive();
    tick();
    tick();

    c_rst = 0;
    drive();
    #1;
    chk("reset.pc_out", bus.pc_out, 32'h3000);
    chk("reset.pc_plus4", bus.pc_plus4, 32'h3004);
    chk("reset.fetch_exc", 32'(bus.fetch_exc), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.fetch_valid", 32'(bus.fetch_valid), 32'd1);

    foreach (tbl[k]) begin
      vec_t v;
      string tag;
      v = tbl[k];
      tag = $sformatf("vec%0d", k);
      for (int i = 0; i < NS; i++) slot[i] = 32'h0000_5550;
      if (int'(v.sel) < NS) slot[v.sel] = v.slot;
      c_rst = v.rst; c_stall = v.stall; c_exc = v.exc; c_eret = v.eret;
      c_rdy = v.rdy; c_sel = v.sel; c_epc = v.epc;
      tick();
      chk({tag, ".pc_out"}, bus.pc_out, v.exp_pc);
      chk({tag, ".pc_plus4"}, bus.pc_plus4, v.exp_pc + 32'd4);
      chk({tag, ".busy"}, 32'(bus.busy), 32'(v.exp_busy));
      chk({tag, ".fetch_exc"}, 32'(bus.fetch_exc), 32'(v.exp_fexc));
      chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(v.rdy && !v.exp_fexc && !v.exp_busy));
    end

    // Randomized run against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        slot[i] = ($urandom_range(0, 3) == 0) ? $urandom
                                               : 32'h3000 + ($urandom_range(0, 16383) << 2);
      c_rst   = ($urandom_range(0, 31) == 0);
      c_exc   = ($urandom_range(0, 15) == 0);
      c_eret  = ($urandom_range(0, 15) == 0);
      c_stall = ($urandom_range(0, 3) == 0);
      c_rdy   = ($urandom_range(0, 3) != 0);
      c_sel   = 3'($urandom_range(0, 7));
      c_epc   = 32'h3000 + ($urandom_range(0, 4095) << 2);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
